// File: rtl/gate_response_checker.sv
// Scores the seven outputs of the two-input gate block against their truth table and gives a pass/fail verdict.
// Optional macro GATE_CHECK_STOP_ON_FAIL_EN ends the run on the first scored mismatch.
module gate_response_checker #(
    parameter int NUM_VEC = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic [6:0]       in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [6:0]       first_err_mask
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // RUN   | accepting vectors, scoring stage 1
    // DRAIN | last vector accepted, scoring it
    // DONE  | verdict valid, waiting for start
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rem_cnt;
    logic             accept;
    logic             last_accept;
    logic             clear;
    logic             s1_valid;
    logic             s1_a;
    logic             s1_b;
    logic [6:0]       s1_y;
    logic [6:0]       s1_exp;
    logic [6:0]       mask;
    logic             mismatch;
    logic             first_fail;
    logic             stop_now;

    function automatic logic [6:0] expected_y(input logic a, input logic b);
        return {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    assign accept      = in_valid & in_ready;
    assign last_accept = accept & (rem_cnt == CNT_ONE);
    assign clear       = start & ((state == IDLE) | (state == DONE));
    assign mask        = s1_y ^ s1_exp;
    assign mismatch    = s1_valid & (mask != 7'd0);
    assign first_fail  = mismatch & (err_cnt == '0);

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    assign stop_now = first_fail & (state == RUN);
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                if (stop_now)         state_nxt = DONE;
                else if (last_accept) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE:  if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN) | (state == DRAIN);
        done     = (state == DONE);
        pass     = (state == DONE) & (err_cnt == '0) & (cov == 4'hF);
    end

    // Remaining-vector down-counter; terminal count 1 marks the final accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_cnt <= '0;
        end else if (clear) begin
            rem_cnt <= NUM_VEC_C;
        end else if (accept && rem_cnt != '0) begin
            rem_cnt <= rem_cnt - CNT_ONE;
        end
    end

    // A vector accepted while the run is being stopped is dropped here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= 1'b0;
            s1_b     <= 1'b0;
            s1_y     <= 7'd0;
            s1_exp   <= 7'd0;
        end else begin
            s1_valid <= accept & ~stop_now & ~clear;
            if (accept) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_y   <= in_y;
                s1_exp <= expected_y(in_a, in_b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt        <= '0;
            err_cnt        <= '0;
            cov            <= 4'd0;
            first_err_idx  <= '0;
            first_err_mask <= 7'd0;
        end else if (clear) begin
            vec_cnt        <= '0;
            err_cnt        <= '0;
            cov            <= 4'd0;
            first_err_idx  <= '0;
            first_err_mask <= 7'd0;
        end else if (s1_valid) begin
            if (vec_cnt != CNT_MAX) vec_cnt <= vec_cnt + CNT_ONE;
            cov[{s1_a, s1_b}] <= 1'b1;
            if (mismatch) begin
                if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
                if (first_fail) begin
                    first_err_idx  <= vec_cnt;
                    first_err_mask <= mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: run-level model checked every cycle plus literal checkpoints.
module tb_gate_response_checker;

    localparam int NUM_VEC = 4;
    localparam int CNT_W   = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             in_a;
    logic             in_b;
    logic [6:0]       in_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       cov;
    logic [CNT_W-1:0] first_err_idx;
    logic [6:0]       first_err_mask;

    gate_response_checker #(.NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy), .done(done), .pass(pass),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .cov(cov),
        .first_err_idx(first_err_idx), .first_err_mask(first_err_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table indexed by {a,b}, bit0=y1 .. bit6=y7, written out by hand.
    logic [6:0] truth [4] = '{7'b1101100, 7'b1010110, 7'b0010110, 7'b0100011};

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Run-level model: counts accepts, scores one cycle later, stops after one drain cycle.
    bit         m_ready, m_busy, m_done, m_pend, m_acc_now, m_stop, m_draining;
    int         m_acc, m_vec, m_err, m_fidx;
    logic [3:0] m_cov;
    logic [6:0] m_fmask, m_py, m_diff;
    logic [1:0] m_pab;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 0; m_busy = 0; m_done = 0; m_pend = 0; m_acc = 0;
            m_vec = 0; m_err = 0; m_fidx = 0; m_cov = 4'd0; m_fmask = 7'd0;
        end else if (start && !m_busy) begin
            m_ready = 1; m_busy = 1; m_done = 0; m_pend = 0; m_acc = 0;
            m_vec = 0; m_err = 0; m_fidx = 0; m_cov = 4'd0; m_fmask = 7'd0;
        end else begin
            m_acc_now  = in_valid && m_ready;
            m_draining = m_busy && !m_ready;
            m_stop     = 0;
            if (m_pend) begin
                m_diff = m_py ^ truth[m_pab];
                m_cov[m_pab] = 1'b1;
                if (m_diff != 7'd0) begin
                    if (m_err == 0) begin
                        m_fidx  = m_vec;
                        m_fmask = m_diff;
                        m_stop  = STOP && m_ready;
                    end
                    if (m_err < MAXC) m_err++;
                end
                if (m_vec < MAXC) m_vec++;
            end
            m_pend = 0;
            if (m_acc_now) begin
                m_acc++;
                m_pend = !m_stop;
                m_pab  = {in_a, in_b};
                m_py   = in_y;
                if (m_acc == NUM_VEC) m_ready = 0;
            end
            if (m_stop || m_draining) begin
                m_ready = 0; m_busy = 0; m_done = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc_in_ready", in_ready, m_ready);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
        chk("cyc_pass", pass, m_done && m_err == 0 && m_cov == 4'hF);
        chk("cyc_vec_cnt", vec_cnt, m_vec);
        chk("cyc_err_cnt", err_cnt, m_err);
        chk("cyc_cov", cov, m_cov);
        chk("cyc_first_err_idx", first_err_idx, m_fidx);
        chk("cyc_first_err_mask", first_err_mask, m_fmask);
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic put(input logic a, input logic b, input logic [6:0] y);
        in_valid = 1'b1; in_a = a; in_b = b; in_y = y;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; in_y = 7'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        chk("rst_cov", cov, 0);
        chk("rst_first_err_mask", first_err_mask, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all four combinations, correct outputs
        pulse_start();
        put(0, 0, 7'b1101100);
        put(0, 1, 7'b1010110);
        put(1, 0, 7'b0010110);
        put(1, 1, 7'b0100011);
        idle(0);
        chk("t1_drain_done", done, 0);
        chk("t1_drain_ready", in_ready, 0);
        idle(1);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_vec_cnt", vec_cnt, 4);
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_cov", cov, 4'hF);

        // 2: second vector has y1 flipped
        pulse_start();
        put(0, 0, truth[0]);
        put(0, 1, 7'b1010111);
        put(1, 0, truth[2]);
        put(1, 1, truth[3]);
        idle(2);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_first_err_idx", first_err_idx, 1);
        chk("t2_first_err_mask", first_err_mask, 7'b0000001);
        chk("t2_pass", pass, 0);
        chk("t2_done", done, 1);

        // 3: correct but incomplete coverage
        pulse_start();
        repeat (4) put(1, 1, truth[3]);
        idle(2);
        chk("t3_err_cnt", err_cnt, 0);
        chk("t3_cov", cov, 4'b1000);
        chk("t3_pass", pass, 0);

        // 4: gaps between vectors, start during run, valid held afterwards
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) start = 1'b1;
            put(i[1], i[0], truth[i]);
            start = 1'b0;
            if (i < 3) idle(1);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_ready_after_last", in_ready, 0);
            @(negedge clk);
        end
        idle(1);
        chk("t4_vec_cnt", vec_cnt, 4);
        chk("t4_pass", pass, 1);

        // 5: reset mid-run discards the in-flight vector
        pulse_start();
        put(0, 0, truth[0]);
        put(0, 1, truth[1]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vec_cnt", vec_cnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cov", cov, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("t5_after_rst_vec_cnt", vec_cnt, 0);
        chk("t5_after_rst_done", done, 0);
        pulse_start();
        for (int i = 0; i < 4; i++) put(i[1], i[0], truth[i]);
        idle(2);
        chk("t5_pass", pass, 1);
        chk("t5_vec_cnt", vec_cnt, 4);

        // 6: first vector bad (y3 flipped), followed by good ones
        pulse_start();
        put(0, 0, truth[0] ^ 7'b0000100);
        put(0, 1, truth[1]);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        chk("t6_stop_done", done, 1);
        chk("t6_stop_ready", in_ready, 0);
`endif
        put(1, 0, truth[2]);
        put(1, 1, truth[3]);
        idle(2);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        chk("t6_vec_cnt", vec_cnt, 1);
`else
        chk("t6_vec_cnt", vec_cnt, 4);
`endif
        chk("t6_err_cnt", err_cnt, 1);
        chk("t6_first_err_idx", first_err_idx, 0);
        chk("t6_first_err_mask", first_err_mask, 7'b0000100);
        chk("t6_done", done, 1);
        chk("t6_pass", pass, 0);

        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
